axicb_pkt_arbiter: RTL

- Packet-level arbiter for one switch output port; shares the port between REQ_NB requesters.
- Picks the winner by priority level first, then round-robin within that level.
- Holds the grant until the handshake of the beat flagged last, so packets never interleave.
- Drives the output mux select and the muxed valid/last toward the downstream slave.

---
 rtl/axicb_arb_pkg.sv | 24 ++
 rtl/axicb_rr_pick.sv | 47 ++++
 rtl/axicb_pkt_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/axicb_arb_pkg.sv
// Shared types and helpers for the packet arbiter.
// The watchdog (enabled by AXICB_ARB_TIMEOUT_EN) uses TIMEOUT_CYCLES.
package axicb_arb_pkg;

   localparam int unsigned TIMEOUT_CYCLES = 256;

   typedef enum logic {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } arb_state_t;

   // One-hot to binary index for up to 8 requesters; zero input maps to 0.
   function automatic logic [2:0] onehot2bin(input logic [7:0] oh);
      logic [2:0] b;
      b = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) begin
            b = b | 3'(i);
         end
      end
      return b;
   endfunction

endpackage

// File: rtl/axicb_rr_pick.sv
// Round-robin lowest-index picker for one priority level, with its
// rotation mask register (all-ones after reset).
module axicb_rr_pick #(
   parameter int unsigned REQ_NB = 4,
   parameter int unsigned IDX_W  = $clog2(REQ_NB)
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [REQ_NB-1:0] cand,
   input  logic              rel,
   input  logic [IDX_W-1:0]  rel_idx,
   output logic [REQ_NB-1:0] pick_c
);

   logic [REQ_NB-1:0] mask_q;
   logic [REQ_NB-1:0] mask_d;
   logic [REQ_NB-1:0] masked_c;
   logic [REQ_NB-1:0] sel_c;

   // Fall back to the unmasked set once the rotation has wrapped.
   always_comb begin
      masked_c = cand & mask_q;
      sel_c    = (|masked_c) ? masked_c : cand;
      pick_c   = sel_c & (~sel_c + REQ_NB'(1));
   end

   always_comb begin
      mask_d = mask_q;
      if (rel) begin
         for (int i = 0; i < REQ_NB; i++) begin
            mask_d[i] = (i > int'(rel_idx));
         end
         if (rel_idx == IDX_W'(REQ_NB - 1)) begin
            mask_d = '1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         mask_q <= '1;
      end else begin
         mask_q <= mask_d;
      end
   end

endmodule

// File: rtl/axicb_pkt_arbiter.sv
// Packet-level output-port arbiter: priority first, round-robin within a level,
// grant held until the last beat handshakes. Watchdog under AXICB_ARB_TIMEOUT_EN.
module axicb_pkt_arbiter
   import axicb_arb_pkg::*;
#(
   parameter int unsigned REQ_NB = 4,
   parameter int unsigned PRIO_W = 2
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       srst,
   input  logic                       en,
   input  logic [REQ_NB-1:0]          req_valid,
   input  logic [REQ_NB-1:0]          req_last,
   input  logic [REQ_NB*PRIO_W-1:0]   req_prio,
   input  logic                       out_ready,
   output logic [REQ_NB-1:0]          grant,
   output logic [$clog2(REQ_NB)-1:0]  grant_id,
   output logic                       out_valid,
   output logic                       out_last,
   output logic                       busy,
   output logic                       timeout_err
);

   localparam int unsigned IDX_W  = $clog2(REQ_NB);
   localparam int unsigned LVL_NB = 1 << PRIO_W;

   arb_state_t        state_q, state_d;
   logic [REQ_NB-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]  grant_id_q, grant_id_d;
   logic [PRIO_W-1:0] top_q, top_d;
   logic              busy_q, busy_d;

   logic              clr_c;
   logic              hs_c;
   logic              rel_c;
   logic              tmo_hit_c;
   logic [PRIO_W-1:0] top_c;
   logic [REQ_NB-1:0] pick_c;
   logic [REQ_NB-1:0] cand_lvl [LVL_NB];
   logic [REQ_NB-1:0] pick_lvl [LVL_NB];

   assign clr_c = !aresetn || srst;

   // Highest priority level among valid requesters.
   always_comb begin
      top_c = '0;
      for (int i = 0; i < REQ_NB; i++) begin
         if (req_valid[i] && (req_prio[i*PRIO_W +: PRIO_W] > top_c)) begin
            top_c = req_prio[i*PRIO_W +: PRIO_W];
         end
      end
   end

   for (genvar l = 0; l < LVL_NB; l++) begin : g_lvl
      always_comb begin
         for (int i = 0; i < REQ_NB; i++) begin
            cand_lvl[l][i] = req_valid[i] && (req_prio[i*PRIO_W +: PRIO_W] == PRIO_W'(l));
         end
      end

      axicb_rr_pick #(
         .REQ_NB (REQ_NB),
         .IDX_W  (IDX_W)
      ) u_pick (
         .clk     (aclk),
         .clr     (clr_c),
         .cand    (cand_lvl[l]),
         .rel     (rel_c && (top_q == PRIO_W'(l))),
         .rel_idx (grant_id_q),
         .pick_c  (pick_lvl[l])
      );
   end

   assign pick_c    = pick_lvl[top_c];
   assign out_valid = |(grant_q & req_valid);
   assign out_last  = |(grant_q & req_last);
   assign hs_c      = out_valid && out_ready;

`ifdef AXICB_ARB_TIMEOUT_EN
   localparam int unsigned TIMEOUT = TIMEOUT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(TIMEOUT);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_q, tmo_d;

   // Stall counter: cleared while idle (so entry starts at 0) and on every handshake.
   always_comb begin
      cnt_d     = cnt_q;
      tmo_hit_c = 1'b0;
      if (state_q == IDLE) begin
         cnt_d = '0;
      end else if (hs_c) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
         tmo_hit_c = 1'b1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      tmo_d = tmo_hit_c;
   end

   always_ff @(posedge aclk) begin
      if (clr_c) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end

   assign timeout_err = tmo_q;
`else
   assign tmo_hit_c   = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      top_d      = top_q;
      busy_d     = busy_q;
      rel_c      = 1'b0;
      case (state_q)
         IDLE: begin
            grant_d    = '0;
            grant_id_d = '0;
            busy_d     = 1'b0;
            if (en && (|req_valid)) begin
               state_d    = GRANTED;
               grant_d    = pick_c;
               grant_id_d = IDX_W'(onehot2bin(8'(pick_c)));
               top_d      = top_c;
               busy_d     = 1'b1;
            end
         end
         GRANTED: begin
            if ((hs_c && out_last) || tmo_hit_c) begin
               rel_c      = 1'b1;
               state_d    = IDLE;
               grant_d    = '0;
               grant_id_d = '0;
               busy_d     = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk) begin
      if (clr_c) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         grant_id_q <= '0;
         top_q      <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         top_q      <= top_d;
         busy_q     <= busy_d;
      end
   end

   assign grant    = grant_q;
   assign grant_id = grant_id_q;
   assign busy     = busy_q;

endmodule
